// File: rtl/fib_pkg.sv
// Shared types and constants for the inverse Fibonacci engine and its generator counterpart.
package fib_pkg;

    localparam int FIB_WIDTH   = 32;
    localparam int FIB_IDX_W   = 8;
    localparam int FIB_MAX_IDX = 47;   // largest index whose value fits in FIB_WIDTH bits

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } fib_state_e;

endpackage

// File: rtl/fib_step.sv
// One Fibonacci iteration step: next-pair sum plus equal/greater compare of a against the target.
module fib_step #(
    parameter int AW = 34
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    input  logic [AW-1:0] val,
    output logic [AW-1:0] sum,
    output logic          eq,
    output logic          gt
);

    assign sum = a + b;
    assign eq  = (a == val);
    assign gt  = (a > val);

endmodule

// File: rtl/fib_index.sv
// Inverse Fibonacci engine: finds the index of the largest F(n) <= captured value.
// Optional macro FIB_INDEX_ABORT_EN: start during SEARCH aborts and re-accepts.
module fib_index
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH,
    parameter int IDX_W = FIB_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] fib,
    output logic [IDX_W-1:0] num,
    output logic             is_fib,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Two guard bits keep the first Fibonacci number above any WIDTH-bit value from wrapping.
    localparam int AW = WIDTH + 2;

    fib_state_e       state_q, state_d;
    logic [AW-1:0]    val_q, val_d;
    logic [AW-1:0]    a_q, a_d;
    logic [AW-1:0]    b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] num_q, num_d;
    logic             is_fib_q, is_fib_d;
    logic             done_q, done_d;

    logic [AW-1:0]    step_sum;
    logic             step_eq;
    logic             step_gt;
    logic             accept;

    fib_step #(.AW(AW)) u_step (
        .a   (a_q),
        .b   (b_q),
        .val (val_q),
        .sum (step_sum),
        .eq  (step_eq),
        .gt  (step_gt)
    );

`ifdef FIB_INDEX_ABORT_EN
    assign accept = start;
`else
    assign accept = start && (state_q != ST_SEARCH);
`endif

    always_comb begin
        state_d  = state_q;
        val_d    = val_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        num_d    = num_q;
        is_fib_d = is_fib_q;
        done_d   = done_q;

        if (accept) begin
            val_d   = {2'b00, fib};
            a_d     = '0;
            b_d     = {{(AW-1){1'b0}}, 1'b1};
            idx_d   = '0;
            done_d  = 1'b0;
            state_d = ST_SEARCH;
        end else if (state_q == ST_SEARCH) begin
            if (step_eq) begin
                num_d    = idx_q;
                is_fib_d = 1'b1;
                done_d   = 1'b1;
                state_d  = ST_DONE;
            end else if (step_gt) begin
                // a starts at 0, so overshoot can only happen with idx >= 1.
                num_d    = idx_q - 1'b1;
                is_fib_d = 1'b0;
                done_d   = 1'b1;
                state_d  = ST_DONE;
            end else begin
                a_d   = b_q;
                b_d   = step_sum;
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            val_q    <= '0;
            a_q      <= '0;
            b_q      <= {{(AW-1){1'b0}}, 1'b1};
            idx_q    <= '0;
            num_q    <= '0;
            is_fib_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            val_q    <= val_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            num_q    <= num_d;
            is_fib_q <= is_fib_d;
            done_q   <= done_d;
        end
    end

    assign num       = num_q;
    assign is_fib    = is_fib_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fib_index.sv
// Bench for fib_index: transaction-level reference model checked every cycle, plus literal cases.
module tb_fib_index;
    import fib_pkg::*;

    localparam int WIDTH = FIB_WIDTH;
    localparam int IDX_W = FIB_IDX_W;

`ifdef FIB_INDEX_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] fib;
    logic [IDX_W-1:0] num;
    logic             is_fib;
    logic             done;
    logic [1:0]       dbg_state;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    fib_index #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fib       (fib),
        .num       (num),
        .is_fib    (is_fib),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    longint fib_tab [0:49];

    initial begin
        fib_tab[0] = 0;
        fib_tab[1] = 1;
        for (int k = 2; k < 50; k++) fib_tab[k] = fib_tab[k-1] + fib_tab[k-2];
    end

    // Table lookup: first entry equal to v (smallest index) or first entry above v.
    task automatic model_eval(input logic [WIDTH-1:0] v, output int n, output bit isf, output int lat);
        n = 0; isf = 1'b0; lat = 0;
        for (int k = 0; k < 50; k++) begin
            if (fib_tab[k] == longint'(v)) begin
                n = k; isf = 1'b1; lat = k + 1;
                return;
            end
            if (fib_tab[k] > longint'(v)) begin
                n = k - 1; isf = 1'b0; lat = k + 1;
                return;
            end
        end
    endtask

    logic [IDX_W:0] exp_q [$];   // {is_fib, num} of the search in flight
    bit             m_busy  = 1'b0;
    int             m_cnt   = 0;
    bit             m_done  = 1'b0;
    int             m_num   = 0;
    bit             m_isfib = 1'b0;

    always @(posedge clk) begin
        int  n, l;
        bit  f;
        logic [IDX_W:0] e;
        if (rst) begin
            exp_q.delete();
            m_busy = 0; m_cnt = 0; m_done = 0; m_num = 0; m_isfib = 0;
        end else if (start && (!m_busy || ABORT_EN)) begin
            if (m_busy) void'(exp_q.pop_back());
            model_eval(fib, n, f, l);
            exp_q.push_back({f, n[IDX_W-1:0]});
            m_busy = 1; m_cnt = l; m_done = 0;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                e = exp_q.pop_front();
                m_busy = 0; m_done = 1;
                m_isfib = e[IDX_W];
                m_num = int'(e[IDX_W-1:0]);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (done !== m_done || num !== m_num[IDX_W-1:0] || is_fib !== m_isfib) begin
                fails++;
                $display("FAIL cycle_cmp t=%0t: done=%b num=%0d is_fib=%b, want done=%b num=%0d is_fib=%b",
                         $time, done, num, is_fib, m_done, m_num, m_isfib);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_lit(input logic [WIDTH-1:0] v, input int en, input bit ef, input int el, input string nm);
        int c = 0;
        @(negedge clk); fib = v; start = 1'b1;
        @(negedge clk); start = 1'b0; fib = $urandom;
        while (done !== 1'b1 && c < 100) begin
            @(negedge clk); c++;
            fib = $urandom;
        end
        tests++;
        if (done !== 1'b1 || num !== en[IDX_W-1:0] || is_fib !== ef || c != el) begin
            fails++;
            $display("FAIL %s: done=%b num=%0d is_fib=%b lat=%0d, want done=1 num=%0d is_fib=%b lat=%0d",
                     nm, done, num, is_fib, c, en, ef, el);
        end
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((m_busy || !done) && c < 200) begin @(negedge clk); c++; end
        if (c >= 200) begin
            tests++; fails++;
            $display("FAIL idle_timeout: model still busy after %0d cycles", c);
        end
    endtask

    function automatic logic [WIDTH-1:0] pick_val();
        logic [WIDTH-1:0] v;
        int k = $urandom_range(0, FIB_MAX_IDX);
        case ($urandom_range(0, 4))
            0: v = $urandom;
            1: v = fib_tab[k][WIDTH-1:0];
            2: v = fib_tab[k][WIDTH-1:0] + 1'b1;
            3: v = fib_tab[k][WIDTH-1:0] - 1'b1;
            default: v = WIDTH'($urandom_range(0, 20));
        endcase
        return v;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int c, exp_n;
        rst = 1'b1; start = 1'b0; fib = '0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        repeat (6) @(negedge clk);
        tests++;
        if (done !== 1'b0 || num !== '0 || is_fib !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: done=%b num=%0d is_fib=%b, want 0 0 0", done, num, is_fib);
        end

        run_lit(32'd0,          0,  1'b1, 1,  "val_0");
        run_lit(32'd1,          1,  1'b1, 2,  "val_1");
        run_lit(32'd55,         10, 1'b1, 11, "val_55");
        run_lit(32'd100,        11, 1'b0, 13, "val_100");
        run_lit(32'd2971215073, 47, 1'b1, 48, "val_f47");
        run_lit(32'hFFFF_FFFF,  47, 1'b0, 49, "val_max");

        // Round trip over every representable Fibonacci value; F(2)=1 maps back to 1.
        for (int n = 0; n <= FIB_MAX_IDX; n++) begin
            exp_n = (n == 2) ? 1 : n;
            run_lit(fib_tab[n][WIDTH-1:0], exp_n, 1'b1, exp_n + 1, $sformatf("round_trip_%0d", n));
        end

        // Start held high across DONE restarts immediately.
        @(negedge clk); fib = 32'd5; start = 1'b1;
        repeat (20) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Second start three cycles into a search.
        @(negedge clk); fib = 32'd55; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); fib = 32'd8; start = 1'b1;
        @(negedge clk); start = 1'b0;
        c = 0;
        while (done !== 1'b1 && c < 100) begin @(negedge clk); c++; end
        tests++;
        if (ABORT_EN) begin
            if (num !== 8'd6 || is_fib !== 1'b1 || c != 7) begin
                fails++;
                $display("FAIL abort_start: num=%0d is_fib=%b lat=%0d, want num=6 is_fib=1 lat=7", num, is_fib, c);
            end
        end else begin
            if (num !== 8'd10 || is_fib !== 1'b1 || c != 8) begin
                fails++;
                $display("FAIL ignore_start: num=%0d is_fib=%b lat=%0d, want num=10 is_fib=1 lat=8", num, is_fib, c);
            end
        end

        // Reset mid-search discards the partial result.
        @(negedge clk); fib = 32'd1000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        tests++;
        if (done !== 1'b0 || num !== '0 || is_fib !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_search: done=%b num=%0d is_fib=%b, want 0 0 0", done, num, is_fib);
        end

        // Randomized traffic: pulses of 1-2 cycles, random gaps, occasional reset (possibly with start).
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                @(negedge clk); rst = 1'b1; start = 1'($urandom_range(0, 1)); fib = $urandom;
                @(negedge clk); rst = 1'b0; start = 1'b0;
            end
            @(negedge clk); fib = pick_val(); start = 1'b1;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            @(negedge clk); start = 1'b0; fib = $urandom;
            repeat ($urandom_range(0, 55)) begin
                @(negedge clk); fib = $urandom;
            end
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
